// File: rtl/wt_cln_cache_pkg.sv
// rtl/wt_cln_cache_pkg.sv - shared WT_CLN controller types
package wt_cln_cache_pkg;

    typedef enum logic [1:0] {
        WT_INVAL_IDLE  = 2'd0,
        WT_INVAL_ISSUE = 2'd1,
        WT_INVAL_DONE  = 2'd2
    } wt_inval_seq_state_e;

endpackage

// File: rtl/wt_duo_inval_sequencer_if.sv
// rtl/wt_duo_inval_sequencer_if.sv - request and invalidation-port bundle of the inval sequencer
interface wt_duo_inval_sequencer_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned CntWidth  = 16
) ();
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [AddrWidth-1:0] req_base_i;
    logic [CntWidth-1:0]  req_lines_i;
    logic                 abort_i;
    logic [AddrWidth-1:0] inval_addr_o;
    logic                 inval_valid_o;
    logic                 inval_ready_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 aborted_o;
    logic [CntWidth-1:0]  lines_sent_o;

    // slave: the sequencer itself; master: requester plus cache side
    modport slave (
        input  req_valid_i, req_base_i, req_lines_i, abort_i, inval_ready_i,
        output req_ready_o, inval_addr_o, inval_valid_o, busy_o, done_o,
               aborted_o, lines_sent_o
    );

    modport master (
        output req_valid_i, req_base_i, req_lines_i, abort_i, inval_ready_i,
        input  req_ready_o, inval_addr_o, inval_valid_o, busy_o, done_o,
               aborted_o, lines_sent_o
    );
endinterface

// File: rtl/wt_duo_inval_sequencer.sv
// rtl/wt_duo_inval_sequencer.sv - walks a line range into the duo cache invalidation port
module wt_duo_inval_sequencer
    import wt_cln_cache_pkg::*;
#(
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned LineOffset = 4,
    parameter int unsigned CntWidth   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    wt_duo_inval_sequencer_if.slave  bus
);

    localparam logic [AddrWidth-1:0] LineBytes = AddrWidth'(1) << LineOffset;
    localparam logic [AddrWidth-1:0] AlignMask = ~(LineBytes - AddrWidth'(1));

    wt_inval_seq_state_e  r_state;
    wt_inval_seq_state_e  w_next_state;
    logic [AddrWidth-1:0] r_cur_addr;
    logic [CntWidth-1:0]  r_remaining;
    logic [CntWidth-1:0]  r_lines_sent;
    logic                 r_abort_flag;
    logic                 r_aborted;
    logic                 w_accept;
    logic                 w_beat;
    logic                 w_last;

    assign w_accept = (r_state == WT_INVAL_IDLE) && bus.req_valid_i;
    assign w_beat   = (r_state == WT_INVAL_ISSUE) && bus.inval_ready_i;
    assign w_last   = (r_remaining == CntWidth'(1));

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            WT_INVAL_IDLE: begin
                if (w_accept) begin
                    w_next_state = (bus.req_lines_i != '0) ? WT_INVAL_ISSUE : WT_INVAL_DONE;
                end
            end
            WT_INVAL_ISSUE: begin
                // The registered flag is used so the beat offered with the abort still counts
                if (w_beat && (w_last || r_abort_flag)) begin
                    w_next_state = WT_INVAL_DONE;
                end
            end
            WT_INVAL_DONE: w_next_state = WT_INVAL_IDLE;
            default:       w_next_state = WT_INVAL_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= WT_INVAL_IDLE;
            r_cur_addr   <= '0;
            r_remaining  <= '0;
            r_lines_sent <= '0;
            r_abort_flag <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_lines_sent <= '0;
                r_abort_flag <= 1'b0;
                r_aborted    <= 1'b0;
                if (bus.req_lines_i != '0) begin
                    r_cur_addr  <= bus.req_base_i & AlignMask;
                    r_remaining <= bus.req_lines_i;
                end
            end
            if (r_state == WT_INVAL_ISSUE) begin
                r_abort_flag <= r_abort_flag | bus.abort_i;
                if (w_beat) begin
                    r_cur_addr   <= r_cur_addr + LineBytes;
                    r_remaining  <= r_remaining - CntWidth'(1);
                    r_lines_sent <= r_lines_sent + CntWidth'(1);
                    // A run that finishes on its final beat is a normal completion
                    if (r_abort_flag && !w_last) begin
                        r_aborted <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.req_ready_o   = (r_state == WT_INVAL_IDLE);
    assign bus.inval_valid_o = (r_state == WT_INVAL_ISSUE);
    assign bus.busy_o        = (r_state == WT_INVAL_ISSUE);
    assign bus.done_o        = (r_state == WT_INVAL_DONE);
    assign bus.aborted_o     = (r_state == WT_INVAL_DONE) && r_aborted;
    assign bus.inval_addr_o  = r_cur_addr;
    assign bus.lines_sent_o  = r_lines_sent;

endmodule

// File: tb/tb_wt_duo_inval_sequencer.sv
// tb/tb_wt_duo_inval_sequencer.sv - table-driven bench for the inval sequencer
module tb_wt_duo_inval_sequencer;

    typedef struct {
        logic        chk;
        logic        rst;
        logic        rv;
        logic [63:0] base;
        logic [15:0] lines;
        logic        abt;
        logic        rdy;
        logic        rr;
        logic        iv;
        logic [63:0] addr;
        logic        busy;
        logic        done;
        logic        abd;
        logic [15:0] ls;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    wt_duo_inval_sequencer_if #(.AddrWidth(64), .CntWidth(16)) bus ();

    wt_duo_inval_sequencer #(
        .AddrWidth (64),
        .LineOffset(4),
        .CntWidth  (16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic add(input logic chk, input logic r, input logic rv, input logic [63:0] base,
                       input logic [15:0] lines, input logic abt, input logic rdy,
                       input logic rr, input logic iv, input logic [63:0] addr, input logic busy,
                       input logic done, input logic abd, input logic [15:0] ls);
        vec_t v;
        v.chk = chk; v.rst = r; v.rv = rv; v.base = base; v.lines = lines; v.abt = abt;
        v.rdy = rdy; v.rr = rr; v.iv = iv; v.addr = addr; v.busy = busy; v.done = done;
        v.abd = abd; v.ls = ls;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [63:0] base, input logic [15:0] lines,
                         input logic abt, input logic rdy);
        bus.req_valid_i   = rv;
        bus.req_base_i    = base;
        bus.req_lines_i   = lines;
        bus.abort_i       = abt;
        bus.inval_ready_i = rdy;
    endtask

    initial begin
        int n;
        int accepts;
        int dones;
        drive(1'b0, 64'h0, 16'h0, 1'b0, 1'b0);

        //   chk rst rv base                     lines abt rdy  rr iv addr                    bsy dn ab ls
        add(0, 1, 0, 64'h0,                  16'd0,  0, 0,   0, 0, 64'h0,                  0, 0, 0, 16'd0);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 0,   1, 0, 64'h0,                  0, 0, 0, 16'd0);
        // basic run
        add(1, 0, 1, 64'h8000_0013,          16'd3,  0, 1,   1, 0, 64'h0,                  0, 0, 0, 16'd0);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 1, 64'h8000_0010,          1, 0, 0, 16'd0);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 1, 64'h8000_0020,          1, 0, 0, 16'd1);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 1, 64'h8000_0030,          1, 0, 0, 16'd2);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 0, 64'h8000_0040,          0, 1, 0, 16'd3);
        // backpressure
        add(1, 0, 1, 64'h1000,               16'd2,  0, 0,   1, 0, 64'h8000_0040,          0, 0, 0, 16'd3);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 0,   0, 1, 64'h1000,               1, 0, 0, 16'd0);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 0,   0, 1, 64'h1000,               1, 0, 0, 16'd0);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 1, 64'h1000,               1, 0, 0, 16'd0);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 1, 64'h1010,               1, 0, 0, 16'd1);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 0, 64'h1020,               0, 1, 0, 16'd2);
        // zero lines
        add(1, 0, 1, 64'h5550,               16'd0,  0, 1,   1, 0, 64'h1020,               0, 0, 0, 16'd2);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 0, 64'h1020,               0, 1, 0, 16'd0);
        // abort mid-run
        add(1, 0, 1, 64'h2000,               16'd10, 0, 1,   1, 0, 64'h1020,               0, 0, 0, 16'd0);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 1, 64'h2000,               1, 0, 0, 16'd0);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 1, 64'h2010,               1, 0, 0, 16'd1);
        add(1, 0, 0, 64'h0,                  16'd0,  1, 1,   0, 1, 64'h2020,               1, 0, 0, 16'd2);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 1, 64'h2030,               1, 0, 0, 16'd3);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 0, 64'h2040,               0, 1, 1, 16'd4);
        // wrap-around
        add(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF5, 16'd2, 0, 1,   1, 0, 64'h2040,               0, 0, 0, 16'd4);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 1, 64'hFFFF_FFFF_FFFF_FFF0, 1, 0, 0, 16'd0);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 1, 64'h0,                  1, 0, 0, 16'd1);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 0, 64'h10,                 0, 1, 0, 16'd2);
        // abort on the final beat completes normally
        add(1, 0, 1, 64'h3000,               16'd2,  0, 1,   1, 0, 64'h10,                 0, 0, 0, 16'd2);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 1, 64'h3000,               1, 0, 0, 16'd0);
        add(1, 0, 0, 64'h0,                  16'd0,  1, 1,   0, 1, 64'h3010,               1, 0, 0, 16'd1);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 0, 64'h3020,               0, 1, 0, 16'd2);
        // abort in IDLE is ignored, then reset with a stalled beat
        add(1, 0, 0, 64'h0,                  16'd0,  1, 1,   1, 0, 64'h3020,               0, 0, 0, 16'd2);
        add(1, 0, 1, 64'h4000,               16'd3,  0, 1,   1, 0, 64'h3020,               0, 0, 0, 16'd2);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   0, 1, 64'h4000,               1, 0, 0, 16'd0);
        add(1, 1, 0, 64'h0,                  16'd0,  0, 0,   0, 1, 64'h4010,               1, 0, 0, 16'd1);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 0,   1, 0, 64'h0,                  0, 0, 0, 16'd0);
        add(1, 0, 0, 64'h0,                  16'd0,  0, 1,   1, 0, 64'h0,                  0, 0, 0, 16'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;
            drive(vecs[i].rv, vecs[i].base, vecs[i].lines, vecs[i].abt, vecs[i].rdy);
            #1;
            if (vecs[i].chk) begin
                checks++;
                if ({bus.req_ready_o, bus.inval_valid_o, bus.inval_addr_o, bus.busy_o,
                     bus.done_o, bus.aborted_o, bus.lines_sent_o} !==
                    {vecs[i].rr, vecs[i].iv, vecs[i].addr, vecs[i].busy,
                     vecs[i].done, vecs[i].abd, vecs[i].ls}) begin
                    errors++;
                    $display("FAIL vec%0d got rr=%b iv=%b addr=%h busy=%b done=%b ab=%b ls=%0d expected rr=%b iv=%b addr=%h busy=%b done=%b ab=%b ls=%0d",
                             i, bus.req_ready_o, bus.inval_valid_o, bus.inval_addr_o, bus.busy_o,
                             bus.done_o, bus.aborted_o, bus.lines_sent_o,
                             vecs[i].rr, vecs[i].iv, vecs[i].addr, vecs[i].busy,
                             vecs[i].done, vecs[i].abd, vecs[i].ls);
                end
            end
        end

        // abort raised while the first beat is stalled: that beat ends the run
        @(negedge clk); drive(1'b1, 64'h6000, 16'd5, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 64'h0, 16'd0, 1'b1, 1'b0);
        #1; check("stall_hold_addr", bus.inval_addr_o, 64'h6000);
        @(negedge clk); drive(1'b0, 64'h0, 16'd0, 1'b0, 1'b0);
        #1; check("stall_hold_valid", {63'b0, bus.inval_valid_o}, 64'd1);
        @(negedge clk); drive(1'b0, 64'h0, 16'd0, 1'b0, 1'b1);
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!bus.done_o && n < 10);
        check("abort_stall_done", {63'b0, bus.done_o}, 64'd1);
        check("abort_stall_aborted", {63'b0, bus.aborted_o}, 64'd1);
        check("abort_stall_lines", {48'b0, bus.lines_sent_o}, 64'd1);
        check("abort_stall_latency", 64'(n), 64'd1);

        // back-to-back single-line runs with the request held: accept every 3 cycles
        accepts = 0;
        dones   = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            drive(1'b1, 64'h7000, 16'd1, 1'b0, 1'b1);
            #1;
            if (bus.req_ready_o) accepts++;
            if (bus.done_o) dones++;
        end
        check("b2b_accepts", 64'(accepts), 64'd3);
        check("b2b_dones", 64'(dones), 64'd3);
        @(negedge clk); drive(1'b0, 64'h0, 16'd0, 1'b0, 1'b1);
        #1; check("b2b_lines_hold", {48'b0, bus.lines_sent_o}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
